// File: rtl/uart_tx_fifo.sv
`default_nettype none
// =============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO feeding an 8N1 LSB-first UART serializer, BAUDRATE_CNT
//            clocks per bit. Define UART_TX_PARITY_EN to add an even-parity bit.
// Revision : 1.0 - initial release
// =============================================================================
module uart_tx_fifo #(
    parameter  int BAUDRATE_CNT = 234,
    parameter  int FIFO_DEPTH   = 16,
    localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [CW-1:0] fifo_count,
    output logic          busy,
    output logic          tx_done,
    output logic          uart_tx
);

    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam int            BW         = $clog2(BAUDRATE_CNT);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUDRATE_CNT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif

    logic          w_push;
    logic          w_pop;
    logic          w_baud_end;
    logic [7:0]    w_head;

    assign wr_ready   = (count_q != COUNT_FULL);
    assign w_push     = wr_valid && wr_ready;
    assign w_baud_end = (baud_q == BAUD_LAST);
    assign w_head     = mem_q[rd_ptr_q];
    // A pop happens when leaving IDLE or when a stop bit completes with data waiting.
    assign w_pop      = (count_q != '0) &&
                        ((state_q == ST_IDLE) || ((state_q == ST_STOP) && w_baud_end));

    always_comb begin
        count_d = count_q + CW'(w_push) - CW'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_pop) begin
                        shreg_q  <= w_head;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^w_head;
`endif
                        baud_q   <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_end) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shreg_q[0];
                        state_q   <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_baud_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= ST_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            shreg_q   <= shreg_q >> 1;
                            tx_q      <= shreg_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_baud_end) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (w_baud_end) begin
                        baud_q <= '0;
                        done_q <= 1'b1;
                        // Chain straight into the next frame so there is no idle gap.
                        if (w_pop) begin
                            shreg_q  <= w_head;
`ifdef UART_TX_PARITY_EN
                            parity_q <= ^w_head;
`endif
                            tx_q     <= 1'b0;
                            state_q  <= ST_START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign uart_tx    = tx_q;

endmodule
`default_nettype wire
